// File: rtl/ofmap_requant_buffer.sv
// ofmap_requant_buffer: ReLU + round/saturate requantisation of convolution window results,
// one buffered output feature map per filter, then a valid/ready stream of both maps.
module ofmap_requant_buffer #(
   parameter int OUT_DIM  = 7,
   parameter int NUM_FILT = 2,
   parameter int ACC_W    = 32,
   parameter int SHIFT    = 8
) (
   input  logic                                               clk,
   input  logic                                               rst_n,
   input  logic                                               start,
   input  logic signed [ACC_W-1:0]                            y_in,
   input  logic                                               y_valid,
   input  logic [((NUM_FILT > 1) ? $clog2(NUM_FILT) : 1)-1:0] y_filt,
   output logic [7:0]                                         out_data,
   output logic [((NUM_FILT > 1) ? $clog2(NUM_FILT) : 1)-1:0] out_filt,
   output logic [$clog2(OUT_DIM*OUT_DIM)-1:0]                 out_addr,
   output logic                                               out_valid,
   input  logic                                               out_ready,
   output logic                                               busy,
   output logic                                               frame_done,
   output logic                                               err
);
   localparam int MAP   = OUT_DIM * OUT_DIM;
   localparam int TOTAL = MAP * NUM_FILT;
   localparam int FW    = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
   localparam int AW    = $clog2(MAP);
   localparam int CW    = $clog2(MAP + 1);
   localparam int PW    = $clog2(TOTAL + 1);
   localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(1) << (SHIFT - 1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

   state_t                state_q, state_d;
   logic                  collect_en, drain_en;
   logic [CW-1:0]         wr_cnt_q [NUM_FILT];
   logic [CW-1:0]         wr_cnt_d [NUM_FILT];
   logic [NUM_FILT-1:0]   map_full;
   logic [CW-1:0]         wr_sel;
   logic [PW-1:0]         wr_idx;
   logic                  wr_accept, drop, last_hs, rd_load;
   logic signed [ACC_W:0] y_ext, y_rnd;
   logic [7:0]            q_pix;
   logic [7:0]            ofm_mem [TOTAL];
   logic [PW-1:0]         rd_ptr_q;
   logic [FW-1:0]         rd_filt_q, out_filt_q;
   logic [AW-1:0]         rd_addr_q, out_addr_q;
   logic [7:0]            out_data_q;
   logic                  out_valid_q, frame_done_q, err_q;

   // Extend by one bit so the rounding add cannot wrap at the top of the input range.
   assign y_ext = {y_in[ACC_W-1], y_in};
   assign y_rnd = (y_ext + RND) >>> SHIFT;

   always_comb begin
      if (y_ext[ACC_W])          q_pix = 8'd0;
      else if (|y_rnd[ACC_W:8])  q_pix = 8'hFF;
      else                       q_pix = y_rnd[7:0];
   end

   for (genvar gi = 0; gi < NUM_FILT; gi++) begin : g_full
      assign map_full[gi] = (wr_cnt_q[gi] == CW'(MAP));
   end

   assign wr_sel    = wr_cnt_q[y_filt];
   assign wr_idx    = PW'(y_filt) * PW'(MAP) + PW'(wr_sel);
   assign wr_accept = collect_en && y_valid && !start && !map_full[y_filt];
   assign drop      = y_valid && !start && !wr_accept;
   assign last_hs   = out_valid_q && out_ready && (rd_ptr_q == PW'(TOTAL));
   assign rd_load   = drain_en && (!out_valid_q || out_ready) && (rd_ptr_q != PW'(TOTAL));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = S_COLLECT;
      end else begin
         case (state_q)
            S_COLLECT: if (&map_full) state_d = S_DRAIN;
            S_DRAIN:   if (last_hs)   state_d = S_IDLE;
            default:   state_d = state_q;
         endcase
      end
   end

   always_comb begin
      collect_en = 1'b0;
      drain_en   = 1'b0;
      busy       = 1'b0;
      case (state_q)
         S_COLLECT: begin collect_en = 1'b1; busy = 1'b1; end
         S_DRAIN:   begin drain_en   = 1'b1; busy = 1'b1; end
         default:   ;
      endcase
   end

   always_comb begin
      wr_cnt_d = wr_cnt_q;
      if (start) begin
         for (int i = 0; i < NUM_FILT; i++) wr_cnt_d[i] = '0;
      end else if (wr_accept) begin
         wr_cnt_d[y_filt] = wr_sel + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_cnt_q <= '{default: '0};
      else        wr_cnt_q <= wr_cnt_d;
   end

   always_ff @(posedge clk) begin
      if (wr_accept) ofm_mem[wr_idx] <= q_pix;
   end

   // The output register doubles as the RAM read register; it only reloads when empty or
   // when the current beat is taken, which holds the beat during stalls without bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_filt_q   <= '0;
         out_addr_q   <= '0;
         rd_ptr_q     <= '0;
         rd_filt_q    <= '0;
         rd_addr_q    <= '0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         frame_done_q <= last_hs && !start;
         if (start)     err_q <= 1'b0;
         else if (drop) err_q <= 1'b1;
         if (start || !drain_en) begin
            out_valid_q <= 1'b0;
            rd_ptr_q    <= '0;
            rd_filt_q   <= '0;
            rd_addr_q   <= '0;
         end else if (rd_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= ofm_mem[rd_ptr_q];
            out_filt_q  <= rd_filt_q;
            out_addr_q  <= rd_addr_q;
            rd_ptr_q    <= rd_ptr_q + 1'b1;
            if (rd_addr_q == AW'(MAP - 1)) begin
               rd_addr_q <= '0;
               rd_filt_q <= rd_filt_q + 1'b1;
            end else begin
               rd_addr_q <= rd_addr_q + 1'b1;
            end
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_data   = out_data_q;
   assign out_filt   = out_filt_q;
   assign out_addr   = out_addr_q;
   assign out_valid  = out_valid_q;
   assign frame_done = frame_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_ofmap_requant_buffer.sv
// Bench for ofmap_requant_buffer: a map/queue model fed by directed and random frames,
// compared against the DUT outputs every cycle.
module tb_ofmap_requant_buffer;
   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic signed [31:0] y_in = '0;
   logic              y_valid = 1'b0;
   logic [0:0]        y_filt = '0;
   logic [7:0]        out_data;
   logic [0:0]        out_filt;
   logic [5:0]        out_addr;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic              busy, frame_done, err;

   ofmap_requant_buffer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in), .y_valid(y_valid),
      .y_filt(y_filt), .out_data(out_data), .out_filt(out_filt), .out_addr(out_addr),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .frame_done(frame_done),
      .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {int f; int a; int d;} beat_t;

   int    errors = 0, checks = 0;
   beat_t exp_q[$];
   int    m_map [2][49];
   int    m_cnt [2];
   int    pin_exp [2][49];
   bit    m_started = 0, m_err = 0, m_busy = 0;
   int    beat_no = 0, done_cnt = 0, rdy_mode = 0, rdy_ph = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference requantisation: ReLU, round half up at 2^8, clamp to 255.
   function automatic int rq(input longint y);
      longint q;
      if (y < 0) return 0;
      q = (y + 128) / 256;
      if (q > 255) return 255;
      return int'(q);
   endfunction

   function automatic longint rnd_y();
      case ($urandom_range(0, 4))
         0:       return -longint'($urandom_range(1, 100000));
         1:       return longint'($urandom_range(0, 65535));
         2:       return longint'($urandom_range(0, 32'h7FFF_FFFF));
         3:       return longint'($urandom_range(65000, 66000));
         default: return longint'($urandom_range(0, 1000));
      endcase
   endfunction

   task automatic model_clear();
      m_cnt[0] = 0; m_cnt[1] = 0; m_err = 0;
      exp_q.delete();
      for (int f = 0; f < 2; f++)
         for (int a = 0; a < 49; a++) pin_exp[f][a] = -1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send(input int f, input longint y);
      y_valid = 1'b1; y_filt = 1'(f); y_in = 32'(y);
      @(posedge clk);
      if (!m_started || m_cnt[f] == 49) begin
         m_err = 1;
      end else begin
         m_map[f][m_cnt[f]] = rq(y);
         m_cnt[f]++;
         if (m_cnt[0] == 49 && m_cnt[1] == 49)
            for (int g = 0; g < 2; g++)
               for (int a = 0; a < 49; a++) exp_q.push_back('{g, a, m_map[g][a]});
      end
      #1 y_valid = 1'b0;
   endtask

   task automatic do_start(input bit with_sample);
      start = 1'b1;
      if (with_sample) begin y_valid = 1'b1; y_filt = 1'b0; y_in = 32'd1000; end
      @(posedge clk);
      m_started = 1; m_busy = 1; beat_no = 0;
      model_clear();
      #1 start = 1'b0; y_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int c0 = done_cnt;
      int n = 0;
      while (done_cnt == c0 && n < budget) begin @(negedge clk); n++; end
      checks++;
      if (done_cnt == c0) begin
         errors++;
         $display("FAIL frame_done_timeout: got no pulse, expected one within %0d cycles", budget);
      end
      @(posedge clk); #1;
   endtask

   task automatic rand_frame();
      int f;
      while (m_cnt[0] < 49 || m_cnt[1] < 49) begin
         if (m_cnt[0] == 49)      f = 1;
         else if (m_cnt[1] == 49) f = 0;
         else                     f = $urandom_range(0, 1);
         send(f, rnd_y());
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
   endtask

   // Consumer: always ready, fixed 1,0,0,1 pattern, or random.
   initial begin
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       begin out_ready = (rdy_ph == 0 || rdy_ph == 3); rdy_ph = (rdy_ph + 1) % 4; end
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Compare process: checks outputs at every falling edge against the model.
   bit         stall_prev = 0, done_exp = 0, done_next = 0;
   logic [7:0] prev_d;
   logic [0:0] prev_f;
   logic [5:0] prev_a;
   beat_t      cur;

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 0; done_exp = 0;
      end else begin
         done_next = 0;
         check("frame_done", frame_done, done_exp);
         if (done_exp) check("valid_at_done", out_valid, 0);
         check("busy", busy, m_busy);
         check("err", err, m_err);
         if (frame_done) done_cnt++;
         if (stall_prev) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, prev_d);
            check("stall_filt", out_filt, prev_f);
            check("stall_addr", out_addr, prev_a);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_beat: got f=%0d a=%0d d=%0d, expected none",
                        out_filt, out_addr, out_data);
            end else begin
               cur = exp_q.pop_front();
               $display("beat %0d: f=%0d addr=%0d data=%0d", beat_no, out_filt, out_addr, out_data);
               check("beat_filt", out_filt, cur.f);
               check("beat_addr", out_addr, cur.a);
               check("beat_data", out_data, cur.d);
               if (pin_exp[cur.f][cur.a] >= 0) check("pin_data", out_data, pin_exp[cur.f][cur.a]);
               beat_no++;
               if (exp_q.size() == 0) begin done_next = 1; m_busy = 0; end
            end
         end
         done_exp   = done_next;
         stall_prev = out_valid && !out_ready;
         prev_d = out_data; prev_f = out_filt; prev_a = out_addr;
      end
   end

   initial begin
      int d0, guard;
      model_clear();
      #12;
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_filt", out_filt, 0);
      check("rst_addr", out_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_err", err, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      idle(2);

      // Sample while idle is dropped and flags err.
      send(0, 500);
      @(negedge clk); check("idle_sample_err", err, 1);
      @(posedge clk); #1;

      // Start outranks a simultaneous sample: not stored, err cleared and kept low.
      do_start(1);
      @(negedge clk); check("start_sample_err", err, 0); check("start_busy", busy, 1);
      @(posedge clk); #1;

      // Frame A: directed ramps, interleaved, consumer always ready.
      for (int k = 0; k < 49; k++) begin pin_exp[0][k] = k; pin_exp[1][k] = k + 1; end
      rdy_mode = 0;
      d0 = done_cnt;
      for (int k = 0; k < 49; k++) begin send(0, k * 256); send(1, 300 + k * 256); end
      wait_done(400);
      idle(5);
      check("frameA_beats", beat_no, 98);
      check("frameA_done_pulses", done_cnt - d0, 1);

      // Frame B: requant corner values, overflow sample on f0, stalled consumer.
      do_start(0);
      rdy_mode = 1; rdy_ph = 0;
      pin_exp[0][0] = 2; pin_exp[0][1] = 1; pin_exp[0][2] = 0; pin_exp[0][3] = 255;
      send(0, 384); send(0, 383); send(0, -5); send(0, 64'sh7FFF_FFFF);
      for (int k = 4; k < 49; k++) begin
         send(0, rnd_y());
         if (k < 24) send(1, rnd_y());
      end
      send(0, 1000);
      @(negedge clk); check("overflow_err", err, 1);
      @(posedge clk); #1;
      while (m_cnt[1] < 49) send(1, rnd_y());
      wait_done(1000);

      // Frame C: random, reset asynchronously partway through the drain.
      do_start(0);
      rdy_mode = 0;
      rand_frame();
      guard = 0;
      while (beat_no < 20 && guard < 500) begin @(negedge clk); guard++; end
      check("reached_beat20", beat_no >= 20, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", out_valid, 0);
      check("async_rst_data", out_data, 0);
      check("async_rst_filt", out_filt, 0);
      check("async_rst_addr", out_addr, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_done", frame_done, 0);
      check("async_rst_err", err, 0);
      m_started = 0; m_busy = 0;
      model_clear();
      idle(2);
      @(posedge clk); #1 rst_n = 1'b1;
      idle(2);

      // Frames D-F: random data with random and patterned back-pressure.
      for (int fr = 0; fr < 3; fr++) begin
         do_start(0);
         rdy_mode = (fr == 1) ? 1 : 2;
         rand_frame();
         wait_done(1500);
      end
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
